// File: rtl/apb_pkg.sv
`default_nettype none
// apb_pkg: shared state type, protection width and alignment helper for the APB requester. Rev 1.0
package apb_pkg;

  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  // Only word-aligned byte addresses are issued on the bus.
  function automatic logic addr_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_wdog.sv
`default_nettype none
// apb_master_wdog: counts stalled ACCESS cycles and flags the one on which the transfer must be aborted. Rev 1.0
module apb_master_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires in the stalled cycle that would bring the count up to TIMEOUT.
      assign expired = enable && !clear && (cnt_q == LAST);
    end else begin : g_no_wdog
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// apb_master: single-outstanding APB4 requester bridging a valid/ready command/response pair onto APB. Rev 1.0
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [PROT_W-1:0]   cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic [PROT_W-1:0]   prot,
  output logic                pwrite,
  output logic                psel,
  output logic                penable,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic                slverr,
  input  logic [DATA_W-1:0]   prdata
);

  apb_mst_state_e      state_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [PROT_W-1:0]   prot_q;
  logic                pwrite_q;
  logic                psel_q;
  logic                penable_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W/8-1:0] pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic wdog_clear;
  logic wdog_enable;
  logic wdog_expired;

  assign wdog_clear  = (state_q != ST_ACCESS);
  assign wdog_enable = (state_q == ST_ACCESS) && !pready;

  apb_master_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (wdog_clear),
    .enable  (wdog_enable),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      prot_q      <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (addr_aligned(cmd_addr[1:0])) begin
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              pwdata_q <= cmd_wdata;
              prot_q   <= cmd_prot;
              pstrb_q  <= cmd_write ? cmd_strb : '0;
              psel_q   <= 1'b1;
              state_q  <= ST_SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A completing pready wins over a watchdog expiry in the same cycle.
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= slverr;
            rsp_rdata_q <= (pwrite_q || slverr) ? '0 : prdata;
            state_q     <= ST_RESP;
          end else if (wdog_expired) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign prot      = prot_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// tb_apb_master: directed and random transfers against a per-transaction reference model. Rev 1.0
module tb_apb_master;
  import apb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb = '0;
  logic [PROT_W-1:0] cmd_prot = '0;
  logic              rsp_ready = 1'b0;
  logic              pready = 1'b0;
  logic              slverr = 1'b0;
  logic [DATA_W-1:0] prdata = '0;

  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic [PROT_W-1:0] prot;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .prot      (prot),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .slverr    (slverr),
    .prdata    (prdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command end to end; the slave answers on ACCESS cycle waits+1.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] pr, input int waits,
                         input logic serr, input logic [31:0] rdat, input int hold);
    logic        aligned;
    int          exp_access;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          setup_cnt;
    int          access_cnt;
    int          lat;

    aligned    = (addr % 4 == 0);
    setup_cnt  = 0;
    access_cnt = 0;
    lat        = 0;
    if (!aligned) begin
      exp_access = 0;
      exp_err    = 1'b1;
      exp_rdata  = 32'h0;
    end else if (waits >= TMO) begin
      exp_access = TMO;
      exp_err    = 1'b1;
      exp_rdata  = 32'h0;
    end else begin
      exp_access = waits + 1;
      exp_err    = serr;
      exp_rdata  = (wr || serr) ? 32'h0 : rdat;
    end
    exp_lat = aligned ? exp_access + 2 : 1;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = pr;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    cmd_prot  = 3'($urandom);
    cmd_write = ~wr;

    for (int cyc = 1; cyc <= 40; cyc++) begin
      lat = cyc;
      if (rsp_valid) break;
      check("cmd_ready_busy", cmd_ready, 0);
      if (psel) begin
        check("paddr", paddr, addr);
        check("pwrite", pwrite, wr);
        check("pwdata", pwdata, wdata);
        check("pstrb", pstrb, wr ? strb : 4'h0);
        check("prot", prot, pr);
        if (!penable) setup_cnt++;
        else access_cnt++;
      end else begin
        check("penable_without_psel", penable, 0);
      end
      pready = psel && penable && (access_cnt == waits + 1);
      slverr = pready ? serr : 1'b0;
      prdata = pready ? rdat : $urandom;
      step();
    end
    pready = 1'b0;
    slverr = 1'b0;

    check("rsp_valid", rsp_valid, 1);
    check("rsp_latency", lat, exp_lat);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("setup_cycles", setup_cnt, aligned ? 1 : 0);
    check("access_cycles", access_cnt, exp_access);
    check("psel_in_resp", {psel, penable}, 2'b00);

    for (int i = 0; i < hold; i++) begin
      prdata = $urandom;
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_err", rsp_err, exp_err);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
  endtask

  task automatic reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("pre_reset_access", {psel, penable}, 2'b11);
    #2 nrst = 1'b0;
    #1;
    check("reset_async_psel", {psel, penable}, 2'b00);
    check("reset_no_rsp", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    step();
    check("reset_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("reset_quiet", {rsp_valid, psel}, 2'b00);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic        wr;
    logic [31:0] addr;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_prot", prot, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk) nrst = 1'b1;
    step();
    check("cmd_ready_after_reset", cmd_ready, 1);

    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h24, 32'hAAAA5555, 4'hF, 3'd2, 3, 1'b0, 32'h12345678, 0);
    run_txn(1'b1, 32'h20, 32'h00000001, 4'h3, 3'd1, 0, 1'b1, 32'h0, 0);
    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 3'd0, 10, 1'b0, 32'hCAFE0000, 0);
    run_txn(1'b0, 32'h34, 32'h0, 4'hF, 3'd0, 3, 1'b0, 32'h0000BEEF, 0);
    run_txn(1'b1, 32'h13, 32'h5, 4'hF, 3'd7, 0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h44, 32'h0, 4'h0, 3'd5, 1, 1'b0, 32'h77, 5);
    reset_mid();

    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_txn(wr, addr, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
